bubble_spawn_ctrl: RTL
======================

# bubble_spawn_ctrl

Slot allocator and sequencer for the pool of bubble instances. It loads the opening bubble of a level, accepts split events from every active bubble, and issues start pulses with size, direction and start position that launch child bubbles into free slots. It sits between the game-level controller and the NUM_SLOTS bubble instances, and its outputs drive each instance's start, size, direction, startTopX and startTopY inputs.

## Interface
- NUM_SLOTS, 8: number of bubble instances managed (2..16)
- X_GAP, 32: horizontal offset of the right child from the parent's topLeftX
- X_MAX, 600: maximum legal startTopX; the right child X saturates here
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- levelLoad  in  1  one-cycle pulse that clears the pool and spawns the initial bubble
- initSize  in  3  size of the initial bubble
- initX  in  11  startTopX of the initial bubble
- initY  in  11  startTopY of the initial bubble
- split  in  NUM_SLOTS  per-slot split pulse from the bubble instances
- slotX  in  11*NUM_SLOTS  packed topLeftX of each slot (slot i at [11*i+:11])
- slotY  in  11*NUM_SLOTS  packed topLeftY of each slot
- start  out  NUM_SLOTS  per-slot one-cycle launch pulse
- sizeOut  out  3*NUM_SLOTS  per-slot size, held between starts
- direction  out  NUM_SLOTS  per-slot direction (0 = left, 1 = right), held
- startTopX  out  11*NUM_SLOTS  per-slot launch X, held
- startTopY  out  11*NUM_SLOTS  per-slot launch Y, held
- slotActive  out  NUM_SLOTS  slot currently owns a live bubble
- activeCount  out  5  population count of slotActive
- allCleared  out  1  one-cycle pulse when the last active slot is freed
- overflow  out  1  sticky: a child was dropped because no slot was free; cleared by levelLoad

## Operation
- Reset: all outputs 0, pending mask 0, FSM in IDLE.
- Pending mask: each cycle `pending |= split & slotActive`. Split pulses on inactive slots are ignored. The bit for slot p clears when p is picked.
- FSM states:
  - IDLE: if levelLoad, go to LOAD. Else if pending != 0, set p = lowest set index, capture the parent's size s and its X/Y from slotX/slotY, clear pending[p], and go to SPAWN_L.
  - LOAD: slotActive = 0 except slot 0; slot 0 gets start = 1, size = initSize, direction = 1, X/Y = initX/initY. Pending mask cleared, overflow cleared. Return to IDLE.
  - SPAWN_L: if s == 0, clear slotActive[p] and return to IDLE with no start. Else pulse start[p] with size s-1, direction 0, X = parent X, Y = parent Y. Go to SPAWN_R.
  - SPAWN_R: f = lowest index with slotActive == 0. If one exists, set slotActive[f] and pulse start[f] with size s-1, direction 1, X = min(parentX + X_GAP, X_MAX), Y = parent Y. The addition is 12-bit, so it never wraps. If no slot is free, set overflow. Return to IDLE.
- levelLoad has priority in every state. It aborts any split in progress on the next clock, and a partially issued pair is discarded.
- allCleared pulses for one cycle on the clock where slotActive goes from nonzero to 0. It does not pulse on reset or on levelLoad.
- Only one start bit is high in any cycle.

## Timing
- A split at cycle t is registered into pending at t+1. The FSM picks it at t+1, start[p] fires at t+2, and start[f] fires at t+3. The FSM is back in IDLE at t+4.
- Simultaneous splits are serviced lowest index first, 3 cycles each (2 cycles when s == 0). Splits arriving while the FSM is busy are kept in pending and are never lost.
- levelLoad at cycle t: start[0] fires at t+2, via IDLE → LOAD.
- Held outputs (sizeOut, direction, startTopX/Y) change only on the cycle their start bit pulses.
- Asserting resetN low mid-sequence zeroes everything immediately. No start pulse is issued after reset is released until a levelLoad.

## Test plan
- levelLoad with initSize = 3, initX = 300, initY = 50 → start = 0x01 two cycles later, sizeOut[0] = 3, direction[0] = 1, slotActive = 0x01, activeCount = 1.
- split[0] with slotX[0] = 200, slotY[0] = 120 → start[0] at +2 (size 2, dir 0, X 200, Y 120), start[1] at +3 (size 2, dir 1, X 232, Y 120), activeCount = 2.
- Slots 0 and 1 split in the same cycle, both size 2 → slot 0 pair serviced at +2/+3 (right child in slot 2), slot 1 pair at +5/+6 (right child in slot 3).
- A size-0 bubble is the only active slot and splits → no start pulse, slotActive = 0, allCleared pulses exactly once.
- All 8 slots active and one splits with size 1 → start[p] at size 0, no second start, overflow = 1; a later levelLoad clears overflow.
- Parent X = 590 → right child startTopX = 600 (saturated); levelLoad asserted during SPAWN_L → no SPAWN_R pulse, pool reloaded to slot 0 only.

Source files
------------

// File: rtl/bubble_spawn_ctrl.sv
// bubble_spawn_ctrl: slot allocator and launch sequencer for the bubble pool.
// Loads the opening bubble of a level, collects split events from live slots,
// and launches the two children of each split: the left child reuses the
// parent slot, and the right child takes the lowest free slot.
module bubble_spawn_ctrl #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned X_GAP     = 32,
  parameter int unsigned X_MAX     = 600
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      levelLoad,
  input  logic [2:0]                initSize,
  input  logic [10:0]               initX,
  input  logic [10:0]               initY,
  input  logic [NUM_SLOTS-1:0]      split,
  input  logic [11*NUM_SLOTS-1:0]   slotX,
  input  logic [11*NUM_SLOTS-1:0]   slotY,
  output logic [NUM_SLOTS-1:0]      start,
  output logic [3*NUM_SLOTS-1:0]    sizeOut,
  output logic [NUM_SLOTS-1:0]      direction,
  output logic [11*NUM_SLOTS-1:0]   startTopX,
  output logic [11*NUM_SLOTS-1:0]   startTopY,
  output logic [NUM_SLOTS-1:0]      slotActive,
  output logic [4:0]                activeCount,
  output logic                      allCleared,
  output logic                      overflow
);

  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned COORD_W = 11;
  localparam int unsigned CNT_W   = 5;
  localparam logic [COORD_W:0]   GAP_EXT = (COORD_W+1)'(X_GAP);
  localparam logic [COORD_W:0]   MAX_EXT = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W-1:0] MAX_X   = COORD_W'(X_MAX);

  // SPAWN_L: the left-child pulse (if any) is on the outputs and the right child
  // is being placed; SPAWN_R: the right-child pulse is on the outputs.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SPAWN_L,
    ST_SPAWN_R
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_SLOTS-1:0]      pending_q, pending_d;
  logic [NUM_SLOTS-1:0]      par_mask_q, par_mask_d;
  logic [SIZE_W-1:0]         par_size_q, par_size_d;
  logic [COORD_W-1:0]        par_x_q, par_x_d;
  logic [COORD_W-1:0]        par_y_q, par_y_d;

  logic [NUM_SLOTS-1:0]      start_d;
  logic [SIZE_W*NUM_SLOTS-1:0]  size_d;
  logic [NUM_SLOTS-1:0]      dir_d;
  logic [COORD_W*NUM_SLOTS-1:0] x_d;
  logic [COORD_W*NUM_SLOTS-1:0] y_d;
  logic [NUM_SLOTS-1:0]      active_d;
  logic [CNT_W-1:0]          count_d;
  logic                      all_cleared_d;
  logic                      overflow_d;

  logic [NUM_SLOTS-1:0]      live_pend;
  logic                      pick_found;
  logic [NUM_SLOTS-1:0]      pick_mask;
  logic [SIZE_W-1:0]         pick_size;
  logic [COORD_W-1:0]        pick_x;
  logic [COORD_W-1:0]        pick_y;
  logic                      free_found;
  logic [NUM_SLOTS-1:0]      free_mask;
  logic [COORD_W:0]          right_sum;
  logic [COORD_W-1:0]        right_x;

  assign live_pend = pending_q & slotActive;

  // Lowest pending live slot and the parent attributes it would hand over.
  always_comb begin
    pick_found = 1'b0;
    pick_mask  = '0;
    pick_size  = '0;
    pick_x     = '0;
    pick_y     = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (live_pend[i] && !pick_found) begin
        pick_found   = 1'b1;
        pick_mask[i] = 1'b1;
        pick_size    = sizeOut[SIZE_W*i +: SIZE_W];
        pick_x       = slotX[COORD_W*i +: COORD_W];
        pick_y       = slotY[COORD_W*i +: COORD_W];
      end
    end
  end

  // Lowest free slot for the right child.
  always_comb begin
    free_found = 1'b0;
    free_mask  = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (!slotActive[i] && !free_found) begin
        free_found   = 1'b1;
        free_mask[i] = 1'b1;
      end
    end
  end

  // Right child X: 12-bit add so it cannot wrap, then clamp to the right edge.
  always_comb begin
    right_sum = {1'b0, par_x_q} + GAP_EXT;
    right_x   = (right_sum > MAX_EXT) ? MAX_X : right_sum[COORD_W-1:0];
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      par_mask_q  <= '0;
      par_size_q  <= '0;
      par_x_q     <= '0;
      par_y_q     <= '0;
      start       <= '0;
      sizeOut     <= '0;
      direction   <= '0;
      startTopX   <= '0;
      startTopY   <= '0;
      slotActive  <= '0;
      activeCount <= '0;
      allCleared  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      par_mask_q  <= par_mask_d;
      par_size_q  <= par_size_d;
      par_x_q     <= par_x_d;
      par_y_q     <= par_y_d;
      start       <= start_d;
      sizeOut     <= size_d;
      direction   <= dir_d;
      startTopX   <= x_d;
      startTopY   <= y_d;
      slotActive  <= active_d;
      activeCount <= count_d;
      allCleared  <= all_cleared_d;
      overflow    <= overflow_d;
    end
  end

  // Next-state and next-output logic; levelLoad wins in every state.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | (split & slotActive);
    par_mask_d = par_mask_q;
    par_size_d = par_size_q;
    par_x_d    = par_x_q;
    par_y_d    = par_y_q;
    start_d    = '0;
    size_d     = sizeOut;
    dir_d      = direction;
    x_d        = startTopX;
    y_d        = startTopY;
    active_d   = slotActive;
    overflow_d = overflow;

    case (state_q)
      ST_IDLE: begin
        if (levelLoad) begin
          state_d = ST_LOAD;
        end else if (pick_found) begin
          par_mask_d = pick_mask;
          par_size_d = pick_size;
          par_x_d    = pick_x;
          par_y_d    = pick_y;
          pending_d  = (pending_q & ~pick_mask) | (split & slotActive);
          if (pick_size != '0) begin
            start_d = pick_mask;
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
              if (pick_mask[i]) begin
                size_d[SIZE_W*i +: SIZE_W]   = pick_size - SIZE_W'(1);
                dir_d[i]                     = 1'b0;
                x_d[COORD_W*i +: COORD_W]    = pick_x;
                y_d[COORD_W*i +: COORD_W]    = pick_y;
              end
            end
          end
          state_d = ST_SPAWN_L;
        end
      end

      ST_SPAWN_L: begin
        if (levelLoad) begin
          state_d = ST_LOAD;
        end else if (par_size_q == '0) begin
          // Smallest bubble pops without children and frees its slot.
          active_d = slotActive & ~par_mask_q;
          state_d  = ST_IDLE;
        end else begin
          if (free_found) begin
            active_d = slotActive | free_mask;
            start_d  = free_mask;
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
              if (free_mask[i]) begin
                size_d[SIZE_W*i +: SIZE_W]   = par_size_q - SIZE_W'(1);
                dir_d[i]                     = 1'b1;
                x_d[COORD_W*i +: COORD_W]    = right_x;
                y_d[COORD_W*i +: COORD_W]    = par_y_q;
              end
            end
          end else begin
            overflow_d = 1'b1;
          end
          state_d = ST_SPAWN_R;
        end
      end

      ST_SPAWN_R: begin
        state_d = levelLoad ? ST_LOAD : ST_IDLE;
      end

      ST_LOAD: begin
        active_d                = NUM_SLOTS'(1);
        start_d                 = NUM_SLOTS'(1);
        size_d[SIZE_W-1:0]      = initSize;
        dir_d[0]                = 1'b1;
        x_d[COORD_W-1:0]        = initX;
        y_d[COORD_W-1:0]        = initY;
        pending_d               = '0;
        overflow_d              = 1'b0;
        state_d                 = levelLoad ? ST_LOAD : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Population count and pool-empty edge, both taken from the next slot mask.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      count_d = count_d + CNT_W'(active_d[i]);
    end
    all_cleared_d = (|slotActive) && !(|active_d);
  end

endmodule
